// File: rtl/seq_match_pkg.sv
// Shared types and helpers for the serial pattern-match controller.
package seq_match_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    function automatic logic len_legal(input int len, input int pat_w);
        return (len != 0) && (len <= pat_w);
    endfunction

endpackage

// File: rtl/seq_shift_matcher.sv
// Shift history plus fill tracking; flags a hit on the bit being shifted in.
module seq_shift_matcher
    import seq_match_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             data,
    input  logic             clear,
    input  logic             fill_clear,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    logic [PAT_W-1:0] history;
    logic [PAT_W-1:0] history_nxt;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_nxt;

    always_comb begin
        history_nxt = {history[PAT_W-2:0], data};
        fill_nxt    = (fill >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill + 1'b1;
        // Low len bits set; a shift of PAT_W or more yields all ones.
        mask        = ~({PAT_W{1'b1}} << len);
        hit         = shift && (fill_nxt >= len) &&
                      (((history_nxt ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            history <= '0;
            fill    <= '0;
        end else if (clear) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= history_nxt;
            fill    <= (hit && fill_clear) ? '0 : fill_nxt;
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Session controller: config registers, FSM, match counter and outputs.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             busy,
    output logic             match,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cfg_err
);

    state_t           state;
    state_t           state_nxt;
    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic             overlap_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             load;
    logic             clr;
    logic             count;
    logic             err_nxt;
    logic             shift;
    logic             hit;

    assign shift   = (state == RUN) && in_valid && !abort;
    assign cnt_inc = (&match_cnt) ? match_cnt : match_cnt + 1'b1;
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    seq_shift_matcher #(
        .PAT_W(PAT_W),
        .LEN_W(LEN_W)
    ) u_matcher (
        .clk       (clk),
        .reset     (reset),
        .shift     (shift),
        .data      (in_bit),
        .clear     (clr),
        .fill_clear(!overlap_q),
        .pattern   (pattern_q),
        .len       (len_q),
        .hit       (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clr       = 1'b0;
        count     = 1'b0;
        err_nxt   = 1'b0;
        // A simultaneous config write is seen by the start check.
        len_eff   = cfg_we ? cfg_len : len_q;
        unique case (state)
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    err_nxt = cfg_we;
                    if (hit) begin
                        count = 1'b1;
                        if (target_q != '0 && cnt_inc == target_q)
                            state_nxt = DONE;
                    end
                end
            end
            default: begin
                load = cfg_we;
                if (cfg_we) state_nxt = IDLE;
                if (start && !abort) begin
                    if (len_legal(int'(len_eff), PAT_W)) begin
                        clr       = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_q <= '0;
            len_q     <= LEN_W'(1);
            overlap_q <= 1'b0;
            target_q  <= '0;
            match_cnt <= '0;
            match     <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            match   <= count;
            cfg_err <= err_nxt;
            if (load) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
            end
            if (clr)        match_cnt <= '0;
            else if (count) match_cnt <= cnt_inc;
        end
    end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed and randomized bench for seq_match_ctrl with a queue-based model.
module tb_seq_match_ctrl;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             abort;
    logic             in_valid;
    logic             in_bit;
    logic             busy;
    logic             match;
    logic             done;
    logic [CNT_W-1:0] match_cnt;
    logic             cfg_err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: session state 0=idle 1=running 2=finished.
    int               m_st;
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_ovl;
    int               m_tgt;
    int               m_cnt;
    bit               m_match;
    bit               m_err;
    bit               m_bits[$];

    seq_match_ctrl #(
        .PAT_W(PAT_W),
        .LEN_W(LEN_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_target (cfg_target),
        .start      (start),
        .abort      (abort),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .busy       (busy),
        .match      (match),
        .done       (done),
        .match_cnt  (match_cnt),
        .cfg_err    (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_pat = '0; m_len = 1; m_ovl = 0; m_tgt = 0;
        m_cnt = 0; m_match = 0; m_err = 0;
        m_bits.delete();
    endtask

    task automatic model_edge();
        bit hit;
        m_match = 0;
        m_err   = 0;
        if (m_st == 1) begin
            if (abort) begin
                m_st = 0;
            end else begin
                if (cfg_we) m_err = 1;
                if (in_valid) begin
                    m_bits.push_back(in_bit);
                    if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
                    hit = (m_bits.size() >= m_len);
                    for (int i = 0; i < m_len && hit; i++)
                        if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
                    if (hit) begin
                        m_match = 1;
                        if (m_cnt < 255) m_cnt++;
                        if (!m_ovl) m_bits.delete();
                        if (m_tgt != 0 && m_cnt == m_tgt) m_st = 2;
                    end
                end
            end
        end else begin
            if (cfg_we) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len);
                m_ovl = cfg_overlap; m_tgt = int'(cfg_target);
                m_st  = 0;
            end
            if (start && !abort) begin
                if (m_len >= 1 && m_len <= PAT_W) begin
                    m_bits.delete();
                    m_cnt = 0;
                    m_st  = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [PAT_W-1:0] p, input int l,
                       input bit o, input int t);
        cfg_pattern = p; cfg_len = LEN_W'(l);
        cfg_overlap = o; cfg_target = CNT_W'(t);
        cfg_we = 1; tick(); cfg_we = 0;
    endtask

    task automatic go();
        start = 1; tick(); start = 0;
    endtask

    task automatic stop();
        abort = 1; tick(); abort = 0;
    endtask

    task automatic send(input logic b);
        in_valid = 1; in_bit = b; tick(); in_valid = 0;
    endtask

    task automatic test_reset();
        reset = 0; cfg_we = 0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 0; cfg_target = '0; start = 0; abort = 0;
        in_valid = 0; in_bit = 0;
        model_reset();
        #2;
        n_cmp++;
        if ({busy, match, done, cfg_err, match_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%0d want 0",
                     busy, match, done, cfg_err, match_cnt);
        end
        @(posedge clk); #3;
        reset = 1;
        tick();
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] s = 7'b1010101;
        cfg(8'b10101, 5, 1, 0);
        go();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL ovl_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 7; i++) begin
            send(s[6-i]);
            n_cmp++;
            if (match !== (i == 4 || i == 6)) begin
                n_err++;
                $display("FAIL ovl_match bit%0d: got %b want %b", i + 1, match, (i == 4 || i == 6));
            end
        end
        n_cmp++;
        if (match_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL ovl_cnt: got %0d want 2", match_cnt);
        end
        stop();
        n_cmp++;
        if ({busy, done, match_cnt} !== {2'b00, 8'd2}) begin
            n_err++;
            $display("FAIL abort_hold: got busy=%b done=%b cnt=%0d want 0 0 2", busy, done, match_cnt);
        end
    endtask

    task automatic test_no_overlap();
        logic [6:0] s = 7'b1010101;
        cfg(8'b10101, 5, 0, 0);
        go();
        for (int i = 0; i < 7; i++) begin
            send(s[6-i]);
            n_cmp++;
            if (match !== (i == 4)) begin
                n_err++;
                $display("FAIL novl_match bit%0d: got %b want %b", i + 1, match, (i == 4));
            end
        end
        n_cmp++;
        if (match_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL novl_cnt: got %0d want 1", match_cnt);
        end
        stop();
    endtask

    task automatic test_target();
        logic [5:0] s = 6'b101011;
        cfg(8'b101, 3, 1, 2);
        go();
        for (int i = 0; i < 6; i++) begin
            send(s[5-i]);
            n_cmp++;
            if (match !== (i == 2 || i == 4)) begin
                n_err++;
                $display("FAIL tgt_match bit%0d: got %b want %b", i + 1, match, (i == 2 || i == 4));
            end
            if (i >= 4) begin
                n_cmp++;
                if ({done, busy, match_cnt} !== {2'b10, 8'd2}) begin
                    n_err++;
                    $display("FAIL tgt_done bit%0d: got done=%b busy=%b cnt=%0d want 1 0 2",
                             i + 1, done, busy, match_cnt);
                end
            end
        end
    endtask

    task automatic test_cfg_err();
        cfg(8'b101, 3, 0, 0);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_clears_done: got %b want 0", done);
        end
        go();
        cfg_pattern = '0; cfg_len = 4'd3; cfg_we = 1; tick(); cfg_we = 0;
        n_cmp++;
        if ({cfg_err, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL run_write_err: got err=%b busy=%b want 1 1", cfg_err, busy);
        end
        send(1);
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_one_cycle: got %b want 0", cfg_err);
        end
        send(0);
        send(1);
        n_cmp++;
        if (match !== 1'b1) begin
            n_err++;
            $display("FAIL cfg_unchanged: got match=%b want 1", match);
        end
        stop();
        cfg(8'b0, 0, 0, 0);
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL idle_write_err: got %b want 0", cfg_err);
        end
        go();
        n_cmp++;
        if ({cfg_err, busy} !== 2'b10) begin
            n_err++;
            $display("FAIL len0_start: got err=%b busy=%b want 1 0", cfg_err, busy);
        end
        tick();
        n_cmp++;
        if ({cfg_err, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL len0_after: got err=%b busy=%b want 0 0", cfg_err, busy);
        end
    endtask

    task automatic test_gaps();
        cfg(8'b11, 2, 0, 0);
        go();
        send(1);
        in_bit = 1;
        tick();
        tick();
        n_cmp++;
        if (match !== 1'b0) begin
            n_err++;
            $display("FAIL gap_early: got %b want 0", match);
        end
        send(1);
        n_cmp++;
        if (match !== 1'b1) begin
            n_err++;
            $display("FAIL gap_match: got %b want 1", match);
        end
        tick();
        n_cmp++;
        if ({match, match_cnt} !== {1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL gap_pulse: got match=%b cnt=%0d want 0 1", match, match_cnt);
        end
        stop();
    endtask

    task automatic test_reset_mid();
        logic [4:0] s = 5'b10101;
        cfg(8'b10101, 5, 0, 0);
        go();
        send(1); send(0); send(1);
        #2;
        reset = 0;
        model_reset();
        #1;
        n_cmp++;
        if ({busy, match, done, cfg_err, match_cnt} !== '0) begin
            n_err++;
            $display("FAIL mid_reset: got %b/%b/%b/%b/%0d want 0",
                     busy, match, done, cfg_err, match_cnt);
        end
        #2;
        reset = 1;
        cfg(8'b10101, 5, 0, 0);
        go();
        for (int i = 0; i < 5; i++) send(s[4-i]);
        n_cmp++;
        if ({match, match_cnt} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL post_reset: got match=%b cnt=%0d want 1 1", match, match_cnt);
        end
        stop();
    endtask

    task automatic test_back_to_back();
        cfg(8'b1, 1, 1, 0);
        go();
        for (int i = 0; i < 260; i++) begin
            send(1);
            n_cmp++;
            if ({match, match_cnt} !== {1'b1, CNT_W'((i < 255) ? i + 1 : 255)}) begin
                n_err++;
                $display("FAIL b2b_%0d: got match=%b cnt=%0d want 1 %0d",
                         i, match, match_cnt, (i < 255) ? i + 1 : 255);
            end
        end
        stop();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            cfg_we      = ($urandom_range(0, 19) == 0);
            cfg_pattern = PAT_W'($urandom);
            cfg_len     = LEN_W'($urandom_range(0, 9));
            cfg_overlap = 1'($urandom);
            cfg_target  = CNT_W'($urandom_range(0, 4));
            start       = ($urandom_range(0, 9) == 0);
            abort       = ($urandom_range(0, 59) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_bit      = 1'($urandom);
            tick();
            n_cmp++;
            if ({busy, done, match, cfg_err} !== {m_st == 1, m_st == 2, m_match, m_err}
                || match_cnt !== CNT_W'(m_cnt)) begin
                n_err++;
                $display("FAIL rand_%0d: got b%b d%b m%b e%b c%0d want b%b d%b m%b e%b c%0d",
                         c, busy, done, match, cfg_err, match_cnt,
                         m_st == 1, m_st == 2, m_match, m_err, m_cnt);
            end
        end
        cfg_we = 0; start = 0; abort = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_no_overlap();
        test_target();
        test_cfg_err();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
